// File: rtl/uart_rx_fifo.sv
// Receive-side buffer: drains bytes from the UART unload handshake into a
// first-word-fall-through FIFO and reports occupancy to the register side.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  rxclk,
  input  logic                  reset,
  input  logic                  uart_rx_empty,
  input  logic [7:0]            uart_rx_data,
  input  logic                  uart_uld_rx_ack,
  output logic                  uart_uld_rx_req,
  input  logic                  flush,
  input  logic                  rd,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  rd_err
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = DEPTH_LOG2'(0);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ZERO = (DEPTH_LOG2 + 1)'(0);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_next_s;
  logic                    req_r;
  logic                    req_next_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    rd_err_s;
  logic [7:0]              mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_r;
  logic [DEPTH_LOG2-1:0]   rd_ptr_r;
  logic [DEPTH_LOG2:0]     count_r;
  logic [DEPTH_LOG2:0]     count_next_s;
  logic                    rd_valid_r;
  logic                    full_r;
  logic                    rd_err_r;

  // Drain FSM state and registered unload request
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      req_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      req_r   <= req_next_s;
    end
  end

  // Drain FSM next state; WAIT_DONE makes req and ack both return low
  // before the UART is asked for the next byte
  always_comb begin
    state_next_s = state_r;
    req_next_s   = 1'b0;
    push_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (!uart_rx_empty && !full_r) begin
          state_next_s = WAIT_ACK;
          req_next_s   = 1'b1;
        end else begin
          state_next_s = IDLE;
          req_next_s   = 1'b0;
        end
      end
      WAIT_ACK: begin
        if (uart_uld_rx_ack) begin
          push_s       = 1'b1;
          state_next_s = WAIT_DONE;
          req_next_s   = 1'b0;
        end else begin
          state_next_s = WAIT_ACK;
          req_next_s   = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!uart_uld_rx_ack) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = WAIT_DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
        req_next_s   = 1'b0;
      end
    endcase
  end

  assign pop_s    = rd && rd_valid_r;
  assign rd_err_s = rd && !rd_valid_r;

  // Occupancy after this edge's push/pop
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Pointers and status; flush wins over push, pop and the empty-read error
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      rd_valid_r <= 1'b0;
      full_r     <= 1'b0;
      rd_err_r   <= 1'b0;
    end else if (flush) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      rd_valid_r <= 1'b0;
      full_r     <= 1'b0;
      rd_err_r   <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r    <= count_next_s;
      rd_valid_r <= (count_next_s != CNT_ZERO);
      full_r     <= (count_next_s == CNT_FULL);
      rd_err_r   <= rd_err_s;
    end
  end

  // Byte storage; a write on a flush edge lands in a slot that is now free
  always_ff @(posedge rxclk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= uart_rx_data;
    end
  end

  assign uart_uld_rx_req = req_r;
  assign rd_data         = mem_r[rd_ptr_r];
  assign rd_valid        = rd_valid_r;
  assign full            = full_r;
  assign count           = count_r;
  assign rd_err          = rd_err_r;

endmodule
